fetch_pc_gen: RTL and testbench



---
 rtl/fetch_pc_gen.sv | 92 +++++++++
 tb/tb_fetch_pc_gen.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/fetch_pc_gen.sv
// rtl/fetch_pc_gen.sv - fetch PC generator: boot, sequential walk, redirects, halt after a misaligned group.
// Optional next-PC prediction input is enabled by defining FETCH_PC_GEN_PREDICT_EN.
module fetch_pc_gen #(
    parameter logic [31:0] RESET_PC    = 32'h1c00_0000,
    parameter int          FETCH_WIDTH = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        redirect_valid_i,
    input  logic [31:0] redirect_pc_i,
    input  logic        f_stall_i,
    input  logic        trans_ready_i,
`ifdef FETCH_PC_GEN_PREDICT_EN
    input  logic        predict_valid_i,
    input  logic [31:0] predict_pc_i,
`endif
    output logic [31:0] vaddr_o,
    output logic        valid_o,
    output logic        flush_o
);

    localparam logic [31:0] STRIDE = 32'(4 * FETCH_WIDTH);
    localparam logic [31:0] GROUP_MASK = ~(STRIDE - 32'd1);

    localparam logic [1:0] BOOT = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] HALT = 2'd2;

    logic [1:0]  state;
    logic        adv;
    logic [31:0] seq_pc;
    logic [31:0] next_pc;
    logic        cur_misaligned;

    assign flush_o        = redirect_valid_i;
    assign adv            = valid_o & trans_ready_i & ~f_stall_i;
    assign seq_pc         = (vaddr_o & GROUP_MASK) + STRIDE;
    assign cur_misaligned = |vaddr_o[1:0];

    always_comb begin
        next_pc = seq_pc;
`ifdef FETCH_PC_GEN_PREDICT_EN
        if (predict_valid_i) begin
            next_pc = predict_pc_i;
        end
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= BOOT;
            vaddr_o <= RESET_PC;
            valid_o <= 1'b0;
        end else begin
            case (state)
                BOOT: begin
                    state   <= RUN;
                    valid_o <= 1'b1;
                    if (redirect_valid_i) begin
                        vaddr_o <= redirect_pc_i;
                    end
                end
                RUN: begin
                    if (redirect_valid_i) begin
                        vaddr_o <= redirect_pc_i;
                        valid_o <= 1'b1;
                    end else if (adv) begin
                        // A misaligned group is issued once; then fetch parks until a redirect.
                        if (cur_misaligned) begin
                            state   <= HALT;
                            valid_o <= 1'b0;
                        end else begin
                            vaddr_o <= next_pc;
                        end
                    end
                end
                HALT: begin
                    if (redirect_valid_i) begin
                        state   <= RUN;
                        vaddr_o <= redirect_pc_i;
                        valid_o <= 1'b1;
                    end
                end
                default: begin
                    state   <= BOOT;
                    valid_o <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_pc_gen.sv
// tb/tb_fetch_pc_gen.sv - table-driven directed checks for fetch_pc_gen.
module tb_fetch_pc_gen;

    logic        clk;
    logic        rst_n;
    logic        redirect_valid_i;
    logic [31:0] redirect_pc_i;
    logic        f_stall_i;
    logic        trans_ready_i;
    logic [31:0] vaddr_o;
    logic        valid_o;
    logic        flush_o;
`ifdef FETCH_PC_GEN_PREDICT_EN
    logic        predict_valid_i;
    logic [31:0] predict_pc_i;
`endif

    int n_checks;
    int n_fail;

    typedef struct {
        logic        rv;
        logic [31:0] rpc;
        logic        stall;
        logic        rdy;
        logic [31:0] exp_pc;
        logic        exp_valid;
    } vec_t;

    vec_t vecs[$];

    fetch_pc_gen #(
        .RESET_PC   (32'h1c00_0000),
        .FETCH_WIDTH(2)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .redirect_valid_i(redirect_valid_i),
        .redirect_pc_i   (redirect_pc_i),
        .f_stall_i       (f_stall_i),
        .trans_ready_i   (trans_ready_i),
`ifdef FETCH_PC_GEN_PREDICT_EN
        .predict_valid_i (predict_valid_i),
        .predict_pc_i    (predict_pc_i),
`endif
        .vaddr_o         (vaddr_o),
        .valid_o         (valid_o),
        .flush_o         (flush_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end
    endtask

    // Starts and ends at a falling edge: drive, check flush, clock, check registered outputs.
    task automatic apply(input string name, input vec_t v);
        redirect_valid_i = v.rv;
        redirect_pc_i    = v.rpc;
        f_stall_i        = v.stall;
        trans_ready_i    = v.rdy;
        #1;
        check({name, ".flush"}, {31'd0, flush_o}, {31'd0, v.rv});
        @(posedge clk);
        #1;
        check({name, ".vaddr"}, vaddr_o, v.exp_pc);
        check({name, ".valid"}, {31'd0, valid_o}, {31'd0, v.exp_valid});
        @(negedge clk);
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst_n            = 1'b0;
        redirect_valid_i = 1'b0;
        redirect_pc_i    = 32'h0;
        f_stall_i        = 1'b0;
        trans_ready_i    = 1'b1;
`ifdef FETCH_PC_GEN_PREDICT_EN
        predict_valid_i  = 1'b0;
        predict_pc_i     = 32'h0;
`endif

        //               rv    rpc           stall rdy   exp_pc        exp_valid
        vecs.push_back('{1'b0, 32'h0,        1'b0, 1'b1, 32'h1c000000, 1'b1});
        vecs.push_back('{1'b0, 32'h0,        1'b0, 1'b1, 32'h1c000008, 1'b1});
        vecs.push_back('{1'b0, 32'h0,        1'b0, 1'b1, 32'h1c000010, 1'b1});
        vecs.push_back('{1'b0, 32'h0,        1'b1, 1'b1, 32'h1c000010, 1'b1});
        vecs.push_back('{1'b0, 32'h0,        1'b1, 1'b1, 32'h1c000010, 1'b1});
        vecs.push_back('{1'b0, 32'h0,        1'b1, 1'b1, 32'h1c000010, 1'b1});
        vecs.push_back('{1'b0, 32'h0,        1'b0, 1'b1, 32'h1c000018, 1'b1});
        vecs.push_back('{1'b0, 32'h0,        1'b0, 1'b0, 32'h1c000018, 1'b1});
        vecs.push_back('{1'b0, 32'h0,        1'b0, 1'b0, 32'h1c000018, 1'b1});
        vecs.push_back('{1'b0, 32'h0,        1'b0, 1'b0, 32'h1c000018, 1'b1});
        vecs.push_back('{1'b0, 32'h0,        1'b0, 1'b1, 32'h1c000020, 1'b1});
        vecs.push_back('{1'b1, 32'h1c001004, 1'b1, 1'b1, 32'h1c001004, 1'b1});
        vecs.push_back('{1'b0, 32'h0,        1'b1, 1'b1, 32'h1c001004, 1'b1});
        vecs.push_back('{1'b0, 32'h0,        1'b0, 1'b1, 32'h1c001008, 1'b1});
        vecs.push_back('{1'b1, 32'h1c000102, 1'b0, 1'b1, 32'h1c000102, 1'b1});
        vecs.push_back('{1'b0, 32'h0,        1'b1, 1'b1, 32'h1c000102, 1'b1});
        vecs.push_back('{1'b0, 32'h0,        1'b0, 1'b1, 32'h1c000102, 1'b0});
        vecs.push_back('{1'b0, 32'h0,        1'b0, 1'b1, 32'h1c000102, 1'b0});
        vecs.push_back('{1'b1, 32'h1c000200, 1'b0, 1'b1, 32'h1c000200, 1'b1});
        vecs.push_back('{1'b0, 32'h0,        1'b0, 1'b1, 32'h1c000208, 1'b1});
        vecs.push_back('{1'b1, 32'hfffffff8, 1'b0, 1'b1, 32'hfffffff8, 1'b1});
        vecs.push_back('{1'b0, 32'h0,        1'b0, 1'b1, 32'h00000000, 1'b1});
        vecs.push_back('{1'b0, 32'h0,        1'b0, 1'b1, 32'h00000008, 1'b1});
        vecs.push_back('{1'b1, 32'h1c000040, 1'b0, 1'b1, 32'h1c000040, 1'b1});

        repeat (3) @(posedge clk);
        #1;
        check("reset.vaddr", vaddr_o, 32'h1c000000);
        check("reset.valid", {31'd0, valid_o}, 32'd0);
        check("reset.flush", {31'd0, flush_o}, 32'd0);

        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("boot.valid", {31'd0, valid_o}, 32'd0);
        for (int i = 0; i < vecs.size(); i++) begin
            apply($sformatf("vec%0d", i), vecs[i]);
        end

        // Asynchronous reset between edges while fetching 1c000040.
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst.vaddr", vaddr_o, 32'h1c000000);
        check("async_rst.valid", {31'd0, valid_o}, 32'd0);

        // Redirect presented while in BOOT goes straight to RUN at the target.
        @(negedge clk);
        redirect_valid_i = 1'b1;
        redirect_pc_i    = 32'h1c000300;
        rst_n            = 1'b1;
        apply("boot_redirect", '{1'b1, 32'h1c000300, 1'b0, 1'b1, 32'h1c000300, 1'b1});

        // Back-to-back redirects: last wins, sequential walk resumes from it.
        apply("b2b_a",  '{1'b1, 32'h1c000400, 1'b0, 1'b1, 32'h1c000400, 1'b1});
        apply("b2b_b",  '{1'b1, 32'h1c000500, 1'b1, 1'b0, 32'h1c000500, 1'b1});
        apply("b2b_go", '{1'b0, 32'h0,        1'b0, 1'b1, 32'h1c000508, 1'b1});

`ifdef FETCH_PC_GEN_PREDICT_EN
        predict_valid_i = 1'b1;
        predict_pc_i    = 32'h1c000400;
        apply("pred_vs_redirect", '{1'b1, 32'h1c000800, 1'b0, 1'b1, 32'h1c000800, 1'b1});
        apply("pred_stalled",     '{1'b0, 32'h0,        1'b1, 1'b1, 32'h1c000800, 1'b1});
        apply("pred_taken",       '{1'b0, 32'h0,        1'b0, 1'b1, 32'h1c000400, 1'b1});
        predict_pc_i    = 32'h1c000a02;
        apply("pred_misaligned",  '{1'b0, 32'h0,        1'b0, 1'b1, 32'h1c000a02, 1'b1});
        predict_valid_i = 1'b0;
        apply("pred_halt",        '{1'b0, 32'h0,        1'b0, 1'b1, 32'h1c000a02, 1'b0});
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
